// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_unit_if
// Purpose  : Control/handshake bundle between the accumulator CPU control
//            unit (master) and its register bank / memory port (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_control_unit_if #(
    parameter int OP_W = 4
);
    logic [OP_W-1:0] opcode;
    logic            zflag;
    logic            mem_ack;

    logic            ld_pc;
    logic            pc_sel;
    logic            ld_ir;
    logic            ld_mar;
    logic            mar_sel;
    logic            ld_mdr;
    logic            mdr_sel;
    logic            ld_acc;
    logic            ld_z;
    logic [2:0]      alu_op;
    logic            mem_rd;
    logic            mem_wr;
    logic            halted;
    logic            fault;
    logic [3:0]      state;

    modport master (
        input  opcode, zflag, mem_ack,
        output ld_pc, pc_sel, ld_ir, ld_mar, mar_sel, ld_mdr, mdr_sel,
               ld_acc, ld_z, alu_op, mem_rd, mem_wr, halted, fault, state
    );

    modport slave (
        output opcode, zflag, mem_ack,
        input  ld_pc, pc_sel, ld_ir, ld_mar, mar_sel, ld_mdr, mdr_sel,
               ld_acc, ld_z, alu_op, mem_rd, mem_wr, halted, fault, state
    );
endinterface
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_unit
// Purpose  : Fetch/decode/execute sequencer for the accumulator CPU with a
//            memory rd/wr handshake and optional ack timeout.
//            Optional: CTRL_ILLEGAL_TRAP_EN sends opcodes B-E to FAULT.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
    parameter int OP_W        = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  wire logic          Clk,
    input  wire logic          Rst,
    cpu_control_unit_if.master bus
);
    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_NOT   = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_LDI   = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(4'hF);

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;
    localparam logic [2:0] ALU_IMM  = 3'd6;

    typedef enum logic [3:0] {
        ST_F_ADDR = 4'd0,
        ST_F_MEM  = 4'd1,
        ST_F_IR   = 4'd2,
        ST_DECODE = 4'd3,
        ST_E_ADDR = 4'd4,
        ST_E_RD   = 4'd5,
        ST_E_WB   = 4'd6,
        ST_S_MDR  = 4'd7,
        ST_S_WR   = 4'd8,
        ST_HALT   = 4'd9,
        ST_FAULT  = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d, wait_inc;
    logic             wait_expired;

    logic       ld_pc_o, pc_sel_o, ld_ir_o, ld_mar_o, mar_sel_o;
    logic       ld_mdr_o, mdr_sel_o, ld_acc_o, ld_z_o;
    logic [2:0] alu_op_o;
    logic       mem_rd_o, mem_wr_o, halted_o, fault_o;

    // The limit check looks at the count this cycle would reach, so with
    // ACK_TIMEOUT=N the FSM leaves after exactly N ack-less request cycles.
    always_comb begin
        wait_inc     = wait_q + 1'b1;
        wait_expired = (ACK_TIMEOUT > 0) && (int'(wait_inc) >= ACK_TIMEOUT);
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        ld_pc_o   = 1'b0;
        pc_sel_o  = 1'b0;
        ld_ir_o   = 1'b0;
        ld_mar_o  = 1'b0;
        mar_sel_o = 1'b0;
        ld_mdr_o  = 1'b0;
        mdr_sel_o = 1'b0;
        ld_acc_o  = 1'b0;
        ld_z_o    = 1'b0;
        alu_op_o  = ALU_PASS;
        mem_rd_o  = 1'b0;
        mem_wr_o  = 1'b0;
        halted_o  = 1'b0;
        fault_o   = 1'b0;

        case (state_q)
            ST_F_ADDR: begin
                ld_mar_o = 1'b1;
                state_d  = ST_F_MEM;
            end
            ST_F_MEM: begin
                mem_rd_o = 1'b1;
                if (bus.mem_ack) begin
                    ld_mdr_o = 1'b1;
                    state_d  = ST_F_IR;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_F_IR: begin
                ld_ir_o = 1'b1;
                ld_pc_o = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_NOP: state_d = ST_F_ADDR;
                    OP_JMP: begin
                        ld_pc_o  = 1'b1;
                        pc_sel_o = 1'b1;
                        state_d  = ST_F_ADDR;
                    end
                    OP_JZ: begin
                        ld_pc_o  = bus.zflag;
                        pc_sel_o = bus.zflag;
                        state_d  = ST_F_ADDR;
                    end
                    OP_LDI: begin
                        ld_acc_o = 1'b1;
                        ld_z_o   = 1'b1;
                        alu_op_o = ALU_IMM;
                        state_d  = ST_F_ADDR;
                    end
                    OP_NOT: begin
                        ld_acc_o = 1'b1;
                        ld_z_o   = 1'b1;
                        alu_op_o = ALU_NOT;
                        state_d  = ST_F_ADDR;
                    end
                    OP_HALT: state_d = ST_HALT;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR:
                        state_d = ST_E_ADDR;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = ST_FAULT;
`else
                        state_d = ST_F_ADDR;
`endif
                    end
                endcase
            end
            ST_E_ADDR: begin
                ld_mar_o  = 1'b1;
                mar_sel_o = 1'b1;
                state_d   = (bus.opcode == OP_STORE) ? ST_S_MDR : ST_E_RD;
            end
            ST_E_RD: begin
                mem_rd_o = 1'b1;
                if (bus.mem_ack) begin
                    ld_mdr_o = 1'b1;
                    state_d  = ST_E_WB;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_E_WB: begin
                ld_acc_o = 1'b1;
                ld_z_o   = 1'b1;
                case (bus.opcode)
                    OP_ADD:  alu_op_o = ALU_ADD;
                    OP_SUB:  alu_op_o = ALU_SUB;
                    OP_AND:  alu_op_o = ALU_AND;
                    OP_OR:   alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_PASS;
                endcase
                state_d = ST_F_ADDR;
            end
            ST_S_MDR: begin
                ld_mdr_o  = 1'b1;
                mdr_sel_o = 1'b1;
                state_d   = ST_S_WR;
            end
            ST_S_WR: begin
                mem_wr_o = 1'b1;
                if (bus.mem_ack) begin
                    state_d = ST_F_ADDR;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_HALT:  halted_o = 1'b1;
            ST_FAULT: fault_o  = 1'b1;
            default:  state_d  = ST_FAULT;
        endcase

        // Reset must silence the bus in the very cycle it is asserted,
        // including an in-flight request.
        if (Rst) begin
            ld_pc_o   = 1'b0;
            pc_sel_o  = 1'b0;
            ld_ir_o   = 1'b0;
            ld_mar_o  = 1'b0;
            mar_sel_o = 1'b0;
            ld_mdr_o  = 1'b0;
            mdr_sel_o = 1'b0;
            ld_acc_o  = 1'b0;
            ld_z_o    = 1'b0;
            alu_op_o  = ALU_PASS;
            mem_rd_o  = 1'b0;
            mem_wr_o  = 1'b0;
            halted_o  = 1'b0;
            fault_o   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_F_ADDR;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.ld_pc   = ld_pc_o;
    assign bus.pc_sel  = pc_sel_o;
    assign bus.ld_ir   = ld_ir_o;
    assign bus.ld_mar  = ld_mar_o;
    assign bus.mar_sel = mar_sel_o;
    assign bus.ld_mdr  = ld_mdr_o;
    assign bus.mdr_sel = mdr_sel_o;
    assign bus.ld_acc  = ld_acc_o;
    assign bus.ld_z    = ld_z_o;
    assign bus.alu_op  = alu_op_o;
    assign bus.mem_rd  = mem_rd_o;
    assign bus.mem_wr  = mem_wr_o;
    assign bus.halted  = halted_o;
    assign bus.fault   = fault_o;
    assign bus.state   = state_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control_unit
// Purpose  : Scoreboard bench for cpu_control_unit: per-cycle expected state
//            and strobes are queued with their stimulus and checked as run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;
    localparam int ACK_TO = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    cpu_control_unit_if #(.OP_W(4)) bus ();

    cpu_control_unit #(.OP_W(4), .ACK_TIMEOUT(ACK_TO)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    localparam logic [15:0] X_LDPC   = 16'h8000;
    localparam logic [15:0] X_PCSEL  = 16'h4000;
    localparam logic [15:0] X_LDIR   = 16'h2000;
    localparam logic [15:0] X_LDMAR  = 16'h1000;
    localparam logic [15:0] X_MARSEL = 16'h0800;
    localparam logic [15:0] X_LDMDR  = 16'h0400;
    localparam logic [15:0] X_MDRSEL = 16'h0200;
    localparam logic [15:0] X_LDACC  = 16'h0100;
    localparam logic [15:0] X_LDZ    = 16'h0080;
    localparam logic [15:0] X_ALU    = 16'h0070;
    localparam logic [15:0] X_RD     = 16'h0008;
    localparam logic [15:0] X_WR     = 16'h0004;
    localparam logic [15:0] X_HALT   = 16'h0002;
    localparam logic [15:0] X_FAULT  = 16'h0001;

    typedef struct packed {
        logic [3:0]  op;
        logic        zf;
        logic        ack;
        logic [3:0]  st;
        logic [15:0] outs;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    string      cur   = "init";
    logic [3:0] cur_op = 4'h0;
    logic       cur_zf = 1'b0;
    bit         stray  = 1'b0;

    function automatic logic [15:0] alu(input int code);
        return 16'(code) << 4;
    endfunction

    function automatic logic [15:0] dut_outs();
        return {bus.ld_pc, bus.pc_sel, bus.ld_ir, bus.ld_mar, bus.mar_sel,
                bus.ld_mdr, bus.mdr_sel, bus.ld_acc, bus.ld_z, bus.alu_op,
                bus.mem_rd, bus.mem_wr, bus.halted, bus.fault};
    endfunction

    // Selects and alu_op only matter while their load strobe is active.
    function automatic logic [15:0] care(input logic [15:0] e);
        logic [15:0] m;
        m = ~(X_PCSEL | X_MARSEL | X_MDRSEL | X_ALU);
        if ((e & X_LDPC)  != 16'h0) m = m | X_PCSEL;
        if ((e & X_LDMAR) != 16'h0) m = m | X_MARSEL;
        if ((e & X_LDMDR) != 16'h0) m = m | X_MDRSEL;
        if ((e & X_LDACC) != 16'h0) m = m | X_ALU;
        return m;
    endfunction

    task automatic push(input logic [3:0] st, input logic [15:0] o, input logic ack);
        exp_t r;
        r.op   = cur_op;
        r.zf   = cur_zf;
        r.st   = st;
        r.outs = o;
        // Acks outside the request states must be ignored by the DUT.
        r.ack  = ack | (stray && !(st inside {4'd1, 4'd5, 4'd8}));
        exp_q.push_back(r);
    endtask

    task automatic drain();
        exp_t        r;
        logic [15:0] got, m;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            bus.opcode  = r.op;
            bus.zflag   = r.zf;
            bus.mem_ack = r.ack;
            @(negedge Clk);
            total++;
            if (bus.state !== r.st) begin
                bad++;
                $display("FAIL %s state got=%0d exp=%0d", cur, bus.state, r.st);
            end
            got = dut_outs();
            m   = care(r.outs);
            total++;
            if ((got & m) !== (r.outs & m)) begin
                bad++;
                $display("FAIL %s outs st=%0d got=%h exp=%h mask=%h", cur, r.st, got, r.outs, m);
            end
            @(posedge Clk);
            #1;
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        Rst         = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge Clk);
        total++;
        if (dut_outs() !== 16'h0) begin
            bad++;
            $display("FAIL %s reset_outs got=%h exp=0000", cur, dut_outs());
        end
        @(posedge Clk);
        #1;
        Rst         = 1'b0;
        bus.mem_ack = 1'b0;
    endtask

    task automatic fetch(input logic [3:0] op, input logic zf, input int fwait);
        cur_op = op;
        cur_zf = zf;
        push(4'd0, X_LDMAR, 1'b0);
        repeat (fwait) push(4'd1, X_RD, 1'b0);
        push(4'd1, X_RD | X_LDMDR, 1'b1);
        push(4'd2, X_LDIR | X_LDPC, 1'b0);
    endtask

    task automatic instr(input logic [3:0] op, input logic zf, input int fwait, input int ewait);
        fetch(op, zf, fwait);
        case (op)
            4'h8: push(4'd3, X_LDPC | X_PCSEL, 1'b0);
            4'h9: push(4'd3, zf ? (X_LDPC | X_PCSEL) : 16'h0, 1'b0);
            4'hA: push(4'd3, X_LDACC | X_LDZ | alu(6), 1'b0);
            4'h7: push(4'd3, X_LDACC | X_LDZ | alu(5), 1'b0);
            4'hF: begin
                push(4'd3, 16'h0, 1'b0);
                repeat (3) push(4'd9, X_HALT, 1'b0);
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                push(4'd3, 16'h0, 1'b0);
                push(4'd4, X_LDMAR | X_MARSEL, 1'b0);
                if (op == 4'h2) begin
                    push(4'd7, X_LDMDR | X_MDRSEL, 1'b0);
                    repeat (ewait) push(4'd8, X_WR, 1'b0);
                    push(4'd8, X_WR, 1'b1);
                end else begin
                    repeat (ewait) push(4'd5, X_RD, 1'b0);
                    push(4'd5, X_RD | X_LDMDR, 1'b1);
                    push(4'd6, X_LDACC | X_LDZ | alu((op == 4'h1) ? 0 : int'(op) - 2), 1'b0);
                end
            end
            4'hB, 4'hC, 4'hD, 4'hE: begin
                push(4'd3, 16'h0, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
                push(4'd10, X_FAULT, 1'b0);
                push(4'd10, X_FAULT, 1'b0);
`endif
            end
            default: push(4'd3, 16'h0, 1'b0);
        endcase
    endtask

    task automatic test_reset();
        cur = "reset";
        do_reset();
        instr(4'h0, 1'b0, 0, 0);
        drain();
    endtask

    task automatic test_load();
        cur = "load";
        instr(4'h1, 1'b0, 0, 0);
        drain();
        cur = "load_wait";
        instr(4'h1, 1'b0, 2, 3);
        drain();
    endtask

    task automatic test_store();
        cur = "store";
        instr(4'h2, 1'b0, 0, 3);
        drain();
        instr(4'h2, 1'b1, 3, 0);
        drain();
    endtask

    task automatic test_jumps();
        cur = "jz0";
        instr(4'h9, 1'b0, 0, 0);
        drain();
        cur = "jz1";
        instr(4'h9, 1'b1, 0, 0);
        drain();
        cur = "jmp";
        instr(4'h8, 1'b0, 1, 0);
        drain();
    endtask

    task automatic test_timeout();
        cur = "timeout_fetch";
        cur_op = 4'h0;
        cur_zf = 1'b0;
        push(4'd0, X_LDMAR, 1'b0);
        repeat (ACK_TO) push(4'd1, X_RD, 1'b0);
        push(4'd10, X_FAULT, 1'b0);
        push(4'd10, X_FAULT, 1'b0);
        drain();
        do_reset();
        cur = "timeout_store";
        fetch(4'h2, 1'b0, 0);
        push(4'd3, 16'h0, 1'b0);
        push(4'd4, X_LDMAR | X_MARSEL, 1'b0);
        push(4'd7, X_LDMDR | X_MDRSEL, 1'b0);
        repeat (ACK_TO) push(4'd8, X_WR, 1'b0);
        push(4'd10, X_FAULT, 1'b0);
        drain();
        do_reset();
        cur = "after_fault";
        instr(4'h0, 1'b0, 0, 0);
        drain();
    endtask

    task automatic test_illegal();
        cur = "illegal";
        instr(4'hB, 1'b0, 0, 0);
        drain();
`ifdef CTRL_ILLEGAL_TRAP_EN
        do_reset();
`endif
        instr(4'hE, 1'b1, 0, 0);
        drain();
`ifdef CTRL_ILLEGAL_TRAP_EN
        do_reset();
`endif
    endtask

    task automatic test_halt();
        cur   = "halt";
        stray = 1'b1;
        instr(4'hF, 1'b0, 0, 0);
        drain();
        stray = 1'b0;
        do_reset();
        instr(4'h0, 1'b0, 0, 0);
        drain();
    endtask

    task automatic test_rst_mid();
        cur = "rst_in_e_rd";
        fetch(4'h1, 1'b0, 0);
        push(4'd3, 16'h0, 1'b0);
        push(4'd4, X_LDMAR | X_MARSEL, 1'b0);
        push(4'd5, X_RD, 1'b0);
        push(4'd5, X_RD, 1'b0);
        drain();
        do_reset();
        instr(4'h3, 1'b0, 0, 0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [10];
        cur   = "back_to_back";
        stray = 1'b1;
        ops   = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'h8, 4'h9, 4'h1, 4'h2};
        for (int i = 0; i < 10; i++) begin
            instr(ops[i], 1'($urandom_range(0, 1)), int'($urandom_range(0, ACK_TO - 1)),
                  int'($urandom_range(0, ACK_TO - 1)));
        end
        drain();
        stray = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode  = 4'h0;
        bus.zflag   = 1'b0;
        bus.mem_ack = 1'b0;
        @(posedge Clk);
        #1;
        test_reset();
        test_load();
        test_store();
        test_jumps();
        test_timeout();
        test_illegal();
        test_halt();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
